// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and a borrow flop iterated
// LSB-first over WIDTH clocks; result and final borrow are held until the next op.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_bit;
    logic             bout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;

        d_bit = sa_q[0] ^ sb_q[0] ^ bin_q;
        bout  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bin_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    sa_d    = a;
                    sb_d    = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    res_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d = {d_bit, res_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                bin_d = bout;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the completed word straight from the shift path
                if (cnt_q == LAST) begin
                    state_d  = ST_DONE;
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = bout;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         e;
    int unsigned  vectors = 0;
    int unsigned  miscompares = 0;
    int unsigned  cyc = 0;
    int unsigned  dc_prev = 0;
    int unsigned  dc_last = 0;
    int unsigned  busy_run = 0;
    logic [W-1:0] held_diff = '0;
    logic         held_br = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: plain integer subtraction wrapped to W bits; borrow = unsigned a < b
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t r;
        int   dd;
        dd = int'(x) - int'(y);
        if (dd < 0) dd += (1 << W);
        r.d  = dd[W-1:0];
        r.br = (x < y);
        return r;
    endfunction

    // Monitor
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
            check("diff_hold_run", {24'd0, diff}, {24'd0, held_diff});
            check("borrow_hold_run", {31'd0, borrow_out}, {31'd0, held_br});
        end else if (done) begin
            check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            check("busy_run_len", busy_run, W);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("diff", {24'd0, diff}, {24'd0, e.d});
                check("borrow_out", {31'd0, borrow_out}, {31'd0, e.br});
                held_diff = e.d;
                held_br   = e.br;
            end
            dc_prev  = dc_last;
            dc_last  = cyc;
            busy_run = 0;
        end else begin
            busy_run = 0;
            check("diff_hold_idle", {24'd0, diff}, {24'd0, held_diff});
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ed, input logic eb);
        exp_t t;
        wait_idle();
        a     = x;
        b     = y;
        start = 1'b1;
        t.d   = ed;
        t.br  = eb;
        sb_q.push_back(t);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_t m;
        logic [W-1:0] x, y;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(8'h05, 8'h03, 8'h02, 1'b0);
        issue(8'h03, 8'h05, 8'hFE, 1'b1);
        issue(8'h00, 8'h01, 8'hFF, 1'b1);
        issue(8'hFF, 8'h00, 8'hFF, 1'b0);
        issue(8'h00, 8'h00, 8'h00, 1'b0);
        issue(8'h80, 8'h80, 8'h00, 1'b0);
        drain();

        // start during RUN is ignored
        issue(8'h3C, 8'h11, 8'h2B, 1'b0);
        @(negedge clk);
        a     = 8'hAA;
        b     = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start held high across DONE: back-to-back
        wait_idle();
        a     = 8'h40;
        b     = 8'h01;
        start = 1'b1;
        sb_q.push_back(exp_t'{d: 8'h3F, br: 1'b0});
        @(negedge clk);
        wait_idle();
        a = 8'h10;
        b = 8'h20;
        sb_q.push_back(exp_t'{d: 8'hF0, br: 1'b1});
        @(negedge clk);
        start = 1'b0;
        drain();
        check("done_period", dc_last - dc_prev, W + 1);

        // Asynchronous reset mid-RUN
        issue(8'h77, 8'h12, 8'h65, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_diff", {24'd0, diff}, 32'd0);
        check("midrst_borrow", {31'd0, borrow_out}, 32'd0);
        sb_q.delete();
        held_diff = '0;
        held_br   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(8'h09, 8'h04, 8'h05, 1'b0);
        drain();

        // Random pairs, mixing idle gaps with back-to-back issue
        for (int i = 0; i < 1000; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom_range(0, 15) == 0) y = x;
            m = model(x, y);
            issue(x, y, m.d, m.br);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
